// File: rtl/clock_pkg.sv
// Shared constants for the time display path: 7-segment codes, frame
// geometry and the serial transmit FSM state encoding.
package clock_pkg;

    // Segment byte layout is {dp,g,f,e,d,c,b,a}, active-high.
    localparam logic [7:0] SEG_0     = 8'h3F;
    localparam logic [7:0] SEG_1     = 8'h06;
    localparam logic [7:0] SEG_2     = 8'h5B;
    localparam logic [7:0] SEG_3     = 8'h4F;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'h6D;
    localparam logic [7:0] SEG_6     = 8'h7D;
    localparam logic [7:0] SEG_7     = 8'h07;
    localparam logic [7:0] SEG_8     = 8'h7F;
    localparam logic [7:0] SEG_9     = 8'h6F;
    localparam logic [7:0] SEG_DASH  = 8'h40;
    localparam logic [7:0] SEG_BLANK = 8'h00;

    localparam int DIGITS     = 6;
    localparam int FRAME_BITS = 48;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH
    } state_t;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to 7-segment encoder. Non-BCD codes show a dash.
// Kept standalone so a parallel display driver can reuse it.
module bcd_to_7seg
    import clock_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    input  logic       dp,
    output logic [7:0] seg
);

    // Digit lookup; blanking overrides the glyph, dp is ORed into bit 7.
    always_comb begin
        seg = SEG_DASH;
        case (digit)
            4'd0: seg = SEG_0;
            4'd1: seg = SEG_1;
            4'd2: seg = SEG_2;
            4'd3: seg = SEG_3;
            4'd4: seg = SEG_4;
            4'd5: seg = SEG_5;
            4'd6: seg = SEG_6;
            4'd7: seg = SEG_7;
            4'd8: seg = SEG_8;
            4'd9: seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
        if (blank) seg = SEG_BLANK;
        seg[7] = dp;
    end

endmodule

// File: rtl/display_shift_out.sv
// Serial transmit side of the time display. Snapshots six BCD digits and pm
// on start, encodes them to 7-segment and shifts a 48-bit frame MSB first
// into a 595-style driver chain, then pulses the storage latch.
module display_shift_out
    import clock_pkg::*;
#(
    parameter int CLK_DIV       = 2,
    parameter int LATCH_CYCLES  = 2,
    parameter int BLANK_LEADING = 1,
    parameter int COMMON_ANODE  = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       pm,
    input  logic [3:0] hours_msd,
    input  logic [3:0] hours_lsd,
    input  logic [3:0] minutes_msd,
    input  logic [3:0] minutes_lsd,
    input  logic [3:0] seconds_msd,
    input  logic [3:0] seconds_lsd,
    output logic       busy,
    output logic       done,
    output logic       serial_data,
    output logic       serial_clk,
    output logic       serial_latch
);

    localparam int DIV_MAX = (CLK_DIV > LATCH_CYCLES) ? CLK_DIV : LATCH_CYCLES;
    localparam int CW      = $clog2(DIV_MAX + 1);
    localparam logic [CW-1:0] DIV_LOAD   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] LATCH_LOAD = CW'(LATCH_CYCLES - 1);
    localparam logic [5:0]    TOP_BIT    = 6'(FRAME_BITS - 1);

    // Index 5 is the leftmost digit (hours_msd) so it lands in the frame MSBs.
    logic [DIGITS-1:0][3:0] digits;
    logic [DIGITS-1:0]      blank_sel;
    logic [DIGITS-1:0]      dp_sel;
    logic [DIGITS-1:0][7:0] seg;
    logic [FRAME_BITS-1:0]  frame_enc;

    assign digits    = {hours_msd, hours_lsd, minutes_msd, minutes_lsd, seconds_msd, seconds_lsd};
    assign blank_sel = {((BLANK_LEADING != 0) && (hours_msd == 4'd0)), 5'b0};
    assign dp_sel    = {5'b0, pm};

    for (genvar g = 0; g < DIGITS; g++) begin : g_enc
        bcd_to_7seg u_enc (
            .digit (digits[g]),
            .blank (blank_sel[g]),
            .dp    (dp_sel[g]),
            .seg   (seg[g])
        );
    end

    assign frame_enc = (COMMON_ANODE != 0) ? ~seg : seg;

    state_t                state;
    logic [CW-1:0]         div_cnt;
    logic [5:0]            bit_idx;
    logic [FRAME_BITS-1:0] shreg;

    // Transmit FSM: capture, half-period timing, bit stepping and latch strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            serial_data  <= 1'b0;
            serial_clk   <= 1'b0;
            serial_latch <= 1'b0;
            div_cnt      <= '0;
            bit_idx      <= '0;
            shreg        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg       <= frame_enc;
                        serial_data <= frame_enc[FRAME_BITS-1];
                        serial_clk  <= 1'b0;
                        bit_idx     <= TOP_BIT;
                        div_cnt     <= DIV_LOAD;
                        busy        <= 1'b1;
                        state       <= SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    if (div_cnt == '0) begin
                        serial_clk <= 1'b1;
                        div_cnt    <= DIV_LOAD;
                        state      <= SHIFT_HI;
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                SHIFT_HI: begin
                    if (div_cnt == '0) begin
                        serial_clk <= 1'b0;
                        if (bit_idx == 6'd0) begin
                            serial_latch <= 1'b1;
                            div_cnt      <= LATCH_LOAD;
                            state        <= LATCH;
                        end else begin
                            // Next bit appears on the falling shift clock so it
                            // is stable for a full low+high period.
                            bit_idx     <= bit_idx - 6'd1;
                            shreg       <= {shreg[FRAME_BITS-2:0], 1'b0};
                            serial_data <= shreg[FRAME_BITS-2];
                            div_cnt     <= DIV_LOAD;
                            state       <= SHIFT_LO;
                        end
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                LATCH: begin
                    if (div_cnt == '0) begin
                        serial_latch <= 1'b0;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
